// File: rtl/sram_pkg.sv
// Shared rail levels, slicing threshold and read-sequencer state encoding
// for the SRAM macro read path.
package sram_pkg;

  localparam real VDD      = 1.5;
  localparam real VSS      = 0.0;
  localparam real VTH      = 0.8;
  localparam real V_MARGIN = 0.1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    WL     = 3'd2,
    SAMPLE = 3'd3,
    RESP   = 3'd4
  } rd_state_e;

  // A sense output counts as a clean rail when it lies within the margin of VSS or VDD.
  function automatic logic is_clean_rail(input real v);
    return (v <= (VSS + V_MARGIN)) || (v >= (VDD - V_MARGIN));
  endfunction

endpackage

// File: rtl/sram_row_drv.sv
// Row-select bus driver: puts (addr+1) in binary on the real-valued row lines,
// using the VDD/VSS rails, and holds every line at VSS while disabled.
module sram_row_drv
  import sram_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int AW   = 3
) (
  input  logic [AW-1:0] addr,
  input  logic          en,
  output real           row_rd [0:ROWS-1]
);

  localparam int CW = (ROWS > (AW + 1)) ? ROWS : (AW + 1);

  logic [CW-1:0] code_s;

  // Binary-coded row select; code zero is reserved for "no row selected".
  always_comb begin
    code_s = CW'(addr) + CW'(1'b1);
    for (int s = 0; s < ROWS; s++) begin
      if (en && code_s[s]) begin
        row_rd[s] = VDD;
      end else begin
        row_rd[s] = VSS;
      end
    end
  end

endmodule

// File: rtl/sram_read_seq.sv
// SRAM read sequencer: precharge -> row select -> sense sample -> response.
// Optional macro SRAM_RD_LEVEL_CHECK_EN flags sense outputs that sit between the rails.
module sram_read_seq
  import sram_pkg::*;
#(
  parameter  int ROWS  = 4,
  parameter  int COLS  = 8,
  parameter  int T_PRE = 2,
  parameter  int T_WL  = 3,
  localparam int AW    = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  output logic            pre_en,
  output real             row_rd [0:ROWS-1],
  input  real             preout [0:0][0:COLS-1],
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_data,
  output logic            rsp_err
);

  localparam int T_MAX = (T_PRE > T_WL) ? T_PRE : T_WL;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  rd_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [AW-1:0]    addr_r;
  logic             addr_ok_s;
  logic             row_en_s;
  logic [COLS-1:0]  slice_s;
  logic             lvl_err_s;

  assign addr_ok_s = (addr_r < AW'(ROWS));
  assign row_en_s  = addr_ok_s && ((state_r == WL) || (state_r == SAMPLE));

  sram_row_drv #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_row_drv (
    .addr   (addr_r),
    .en     (row_en_s),
    .row_rd (row_rd)
  );

  // Slice sense outputs at VTH and, when enabled, flag any output off the rails.
  always_comb begin
    slice_s   = {COLS{1'b0}};
    lvl_err_s = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      slice_s[c] = (preout[0][c] >= VTH);
    end
`ifdef SRAM_RD_LEVEL_CHECK_EN
    for (int c = 0; c < COLS; c++) begin
      if (!is_clean_rail(preout[0][c])) begin
        lvl_err_s = 1'b1;
      end else begin
        lvl_err_s = lvl_err_s;
      end
    end
`else
    lvl_err_s = 1'b0;
`endif
  end

  // Read FSM with phase counter and registered handshake/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      addr_r    <= {AW{1'b0}};
      req_ready <= 1'b1;
      pre_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= {COLS{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r    <= req_addr;
            cnt_r     <= CNT_W'(T_PRE - 1);
            state_r   <= PRE;
            req_ready <= 1'b0;
            pre_en    <= 1'b1;
          end else begin
            req_ready <= 1'b1;
          end
        end
        PRE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            cnt_r   <= CNT_W'(T_WL - 1);
            state_r <= WL;
            pre_en  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end
        end
        WL: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= SAMPLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end
        end
        SAMPLE: begin
          // An unselectable row reads as zero and is reported as an error.
          rsp_data  <= addr_ok_s ? slice_s : {COLS{1'b0}};
          rsp_err   <= (!addr_ok_s) || lvl_err_s;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          pre_en    <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_read_seq.sv
// Directed self-checking bench for sram_read_seq (ROWS=4, COLS=8, T_PRE=2, T_WL=3).
module tb_sram_read_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_addr;
  logic       pre_en;
  real        row_rd [0:3];
  real        preout [0:0][0:7];
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_read_seq #(
    .ROWS  (4),
    .COLS  (8),
    .T_PRE (2),
    .T_WL  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .pre_en    (pre_en),
    .row_rd    (row_rd),
    .preout    (preout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    bit         rails_ok;
    obs      = 4'b0000;
    rails_ok = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (row_rd[s] == 1.5) obs[s] = 1'b1;
      else if (row_rd[s] != 0.0) rails_ok = 1'b0;
    end
    n_vec++;
    assert (rails_ok && (obs === exp)) else begin
      n_err++;
      $error("FAIL %s observed=%b rails_ok=%0d expected=%b", tag, obs, rails_ok, exp);
    end
  endtask

  task automatic set_pre(input logic [7:0] bits);
    for (int c = 0; c < 8; c++) preout[0][c] = bits[c] ? 1.5 : 0.0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One read with rsp_ready held high; k counts edges after the accept edge (k=0).
  task automatic do_read(input string tag, input logic [2:0] addr, input logic [3:0] exp_row,
                         input logic [7:0] exp_data, input logic exp_err);
    req_addr  = addr;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        req_valid = 1'b0;
        req_addr  = ~addr;
      end
      chk($sformatf("%s_pre_k%0d", tag, k), pre_en, (k <= 1));
      chk_row($sformatf("%s_row_k%0d", tag, k), (k >= 2 && k <= 5) ? exp_row : 4'b0000);
      chk($sformatf("%s_valid_k%0d", tag, k), rsp_valid, (k == 6));
      chk($sformatf("%s_ready_k%0d", tag, k), req_ready, (k == 7));
      if (k == 6) begin
        chk($sformatf("%s_data", tag), rsp_data, exp_data);
        chk($sformatf("%s_err", tag), rsp_err, exp_err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_lvl_err;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 3'd0;
    rsp_ready = 1'b0;
    set_pre(8'h00);

    // Reset values, observed before the first clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_pre_en", pre_en, 1'b0);
    chk_row("rst_row", 4'b0000);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    #19 rst_n = 1'b1;
    tick();

    // Basic read of row 2: code 3, data 0x85.
    set_pre(8'b1000_0101);
    do_read("rd2", 3'd2, 4'b0011, 8'h85, 1'b0);

    // Out-of-range rows.
    set_pre(8'hFF);
    do_read("oor4", 3'd4, 4'b0000, 8'h00, 1'b1);
    do_read("oor7", 3'd7, 4'b0000, 8'h00, 1'b1);

    // Backpressure in RESP with a competing request held.
    set_pre(8'h0F);
    req_addr  = 3'd1;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) req_valid = 1'b0;
      if (k == 3) chk_row("bp_row_wl", 4'b0010);
    end
    chk("bp_valid_rise", rsp_valid, 1'b1);
    chk("bp_data", rsp_data, 8'h0F);
    chk("bp_err", rsp_err, 1'b0);
    chk_row("bp_row_resp", 4'b0000);
    req_valid = 1'b1;
    req_addr  = 3'd0;
    set_pre(8'hF0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold_valid_%0d", i), rsp_valid, 1'b1);
      chk($sformatf("bp_hold_data_%0d", i), rsp_data, 8'h0F);
      chk($sformatf("bp_hold_ready_%0d", i), req_ready, 1'b0);
      chk($sformatf("bp_hold_pre_%0d", i), pre_en, 1'b0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    tick();
    chk("bp_done_valid", rsp_valid, 1'b0);
    chk("bp_done_ready", req_ready, 1'b1);
    tick();
    chk("bp_idle_pre", pre_en, 1'b0);
    chk("bp_idle_ready", req_ready, 1'b1);

    // Asynchronous reset during WL drops the read.
    set_pre(8'hAA);
    req_addr  = 3'd3;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) req_valid = 1'b0;
    end
    chk_row("ar_row_wl", 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_ready", req_ready, 1'b1);
    chk("ar_pre_en", pre_en, 1'b0);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk_row("ar_row", 4'b0000);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ar_norsp_%0d", i), rsp_valid, 1'b0);
    end
    set_pre(8'h3C);
    do_read("ar_new", 3'd0, 4'b0001, 8'h3C, 1'b0);

    // Mid-level sense output on column 4.
`ifdef SRAM_RD_LEVEL_CHECK_EN
    exp_lvl_err = 1'b1;
`else
    exp_lvl_err = 1'b0;
`endif
    set_pre(8'h02);
    preout[0][4] = 0.9;
    do_read("lvl", 3'd0, 4'b0001, 8'h12, exp_lvl_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
